// File: rtl/bitmap_arb_pkg.sv
// bitmap_read_arbiter shared types: cpu handshake states and grant select.
// Optional build macro BITMAP_ARB_STATS_EN is handled in the top.
package bitmap_arb_pkg;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PEND  = 2'd1,
    C_ACKED = 2'd2
  } cpu_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_DISP = 2'd1,
    G_CPU  = 2'd2
  } grant_t;

endpackage

// File: rtl/bitmap_arb_wait_counter.sv
// Saturating wait counter for a pending cpu request.
// at_limit opens the slot-stealing window.
module bitmap_arb_wait_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [7:0] LIM = 8'(LIMIT);

  logic [7:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_limit)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bitmap_read_arbiter.sv
// Shares the bitmap read port: display has priority, cpu steals bounded slots.
// Define BITMAP_ARB_STATS_EN to add the stat_steal_cnt output.
module bitmap_read_arbiter
  import bitmap_arb_pkg::*;
#(
  parameter  int Nloc         = 1024,
  parameter  int Dbits        = 12,
  parameter  int STARVE_LIMIT = 16,
  localparam int AW           = $clog2(Nloc)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             disp_req,
  input  logic [AW-1:0]    disp_addr,
  output logic [Dbits-1:0] disp_color,
  output logic             disp_color_valid,
  output logic             disp_stolen,
  input  logic             cpu_req,
  input  logic [AW-1:0]    cpu_addr,
  output logic             cpu_ack,
  output logic [Dbits-1:0] cpu_rdata,
  output logic [AW-1:0]    bmem_addr,
  input  logic [Dbits-1:0] bmem_data
`ifdef BITMAP_ARB_STATS_EN
  ,
  output logic [15:0]      stat_steal_cnt
`endif
);

  cpu_state_t state_q, state_d;
  grant_t     grant;

  logic             at_limit;
  logic             steal;
  logic [AW-1:0]    addr_q;
  logic [Dbits-1:0] color_q;
  logic             valid_q;
  logic             stolen_q;
  logic             ack_q;
  logic [Dbits-1:0] rdata_q;

  bitmap_arb_wait_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .inc      ((state_q == C_PEND) && (grant != G_CPU)),
    .clr      (grant == G_CPU),
    .at_limit (at_limit)
  );

  always_comb begin
    grant = G_NONE;
    if (state_q == C_PEND && (!disp_req || at_limit))
      grant = G_CPU;
    else if (disp_req)
      grant = G_DISP;
  end

  always_comb begin
    unique case (grant)
      G_CPU:   bmem_addr = cpu_addr;
      G_DISP:  bmem_addr = disp_addr;
      default: bmem_addr = addr_q;
    endcase
  end

  assign steal = (grant == G_CPU) && disp_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE:  if (cpu_req) state_d = C_PEND;
      C_PEND:  if (grant == G_CPU) state_d = C_ACKED;
      C_ACKED: if (!cpu_req) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // color_q doubles as last_color: it only ever loads a fresh display pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= C_IDLE;
      addr_q   <= '0;
      color_q  <= '0;
      valid_q  <= 1'b0;
      stolen_q <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= bmem_addr;
      valid_q  <= (grant == G_DISP) || steal;
      stolen_q <= steal;
      ack_q    <= (grant == G_CPU);
      if (grant == G_DISP)
        color_q <= bmem_data;
      if (grant == G_CPU)
        rdata_q <= bmem_data;
    end
  end

  assign disp_color       = color_q;
  assign disp_color_valid = valid_q;
  assign disp_stolen      = stolen_q;
  assign cpu_ack          = ack_q;
  assign cpu_rdata        = rdata_q;

`ifdef BITMAP_ARB_STATS_EN
  logic [15:0] steal_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      steal_cnt_q <= '0;
    else if (steal && steal_cnt_q != 16'hFFFF)
      steal_cnt_q <= steal_cnt_q + 16'd1;
  end

  assign stat_steal_cnt = steal_cnt_q;
`endif

endmodule

// File: tb/tb_bitmap_read_arbiter.sv
// Randomized and directed bench for bitmap_read_arbiter against a cycle model.
// Honours BITMAP_ARB_STATS_EN when the design is built with it.
module tb_bitmap_read_arbiter;

  localparam int NLOC = 1024;
  localparam int DB   = 12;
  localparam int SL   = 4;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DB-1:0] disp_color;
  logic          disp_color_valid;
  logic          disp_stolen;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ack;
  logic [DB-1:0] cpu_rdata;
  logic [AW-1:0] bmem_addr;
  logic [DB-1:0] bmem_data;
`ifdef BITMAP_ARB_STATS_EN
  logic [15:0]   stat_steal_cnt;
`endif

  logic [DB-1:0] mem [NLOC];

  assign bmem_data = mem[bmem_addr];

  always #5 clk = ~clk;

  bitmap_read_arbiter #(
    .Nloc         (NLOC),
    .Dbits        (DB),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .disp_req         (disp_req),
    .disp_addr        (disp_addr),
    .disp_color       (disp_color),
    .disp_color_valid (disp_color_valid),
    .disp_stolen      (disp_stolen),
    .cpu_req          (cpu_req),
    .cpu_addr         (cpu_addr),
    .cpu_ack          (cpu_ack),
    .cpu_rdata        (cpu_rdata),
    .bmem_addr        (bmem_addr),
    .bmem_data        (bmem_data)
`ifdef BITMAP_ARB_STATS_EN
    ,
    .stat_steal_cnt   (stat_steal_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: request bookkeeping by cycle numbers.
  bit            m_pend;
  bit            m_need_low;
  int            m_start;
  int            cyc;
  int            m_steals;
  logic [AW-1:0] m_addr;
  logic [DB-1:0] e_color;
  logic [DB-1:0] e_rdata;
  bit            e_valid;
  bit            e_stolen;
  bit            e_ack;

  task automatic model_reset();
    m_pend     = 0;
    m_need_low = 0;
    m_start    = 0;
    cyc        = 0;
    m_steals   = 0;
    m_addr     = '0;
    e_color    = '0;
    e_rdata    = '0;
    e_valid    = 0;
    e_stolen   = 0;
    e_ack      = 0;
  endtask

  task automatic step();
    bit cg;
    bit dg;
    #1;
    cg = m_pend && (!disp_req || (cyc - m_start) >= SL);
    dg = !cg && disp_req;
    if (cg)
      m_addr = cpu_addr;
    else if (dg)
      m_addr = disp_addr;
    check("bmem_addr", 32'(bmem_addr), 32'(m_addr));
    if (dg) begin
      e_color  = mem[disp_addr];
      e_valid  = 1;
      e_stolen = 0;
    end else if (cg && disp_req) begin
      e_valid  = 1;
      e_stolen = 1;
      m_steals++;
    end else begin
      e_valid  = 0;
      e_stolen = 0;
    end
    e_ack = cg;
    if (cg)
      e_rdata = mem[cpu_addr];
    if (cg) begin
      m_pend     = 0;
      m_need_low = 1;
    end else if (m_need_low) begin
      if (!cpu_req)
        m_need_low = 0;
    end else if (!m_pend && cpu_req) begin
      m_pend  = 1;
      m_start = cyc + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
    check("disp_valid", 32'(disp_color_valid), 32'(e_valid));
    check("disp_stolen", 32'(disp_stolen), 32'(e_stolen));
    check("disp_color", 32'(disp_color), 32'(e_color));
    check("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
  endtask

  initial begin
    int n;
    int acks;
    logic [DB-1:0] prev;

    for (int i = 0; i < NLOC; i++)
      mem[i] = DB'($urandom);
    for (int i = 0; i < 4; i++)
      mem[i] = 12'h100 + DB'(i);
    mem[5] = 12'hABC;

    // Reset with a request in flight; request drops as reset releases.
    reset     = 1;
    disp_req  = 0;
    disp_addr = '0;
    cpu_req   = 1;
    cpu_addr  = 10'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 0;
    cpu_req = 0;
    model_reset();
    check("rst_valid", 32'(disp_color_valid), 0);
    check("rst_stolen", 32'(disp_stolen), 0);
    check("rst_color", 32'(disp_color), 0);
    check("rst_ack", 32'(cpu_ack), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_addr", 32'(bmem_addr), 0);
    for (int i = 0; i < 4; i++)
      step();

    // Display only
    for (int i = 0; i < 4; i++) begin
      disp_req  = 1;
      disp_addr = AW'(i);
      step();
      check("disp_pix", 32'(disp_color), 32'h100 + 32'(i));
    end
    disp_req = 0;
    step();

    // Idle-slot cpu read, then req held high: no second ack
    cpu_req  = 1;
    cpu_addr = 10'd5;
    step();
    check("idle_noack", 32'(cpu_ack), 0);
    step();
    check("idle_ack", 32'(cpu_ack), 1);
    check("idle_rdata", 32'(cpu_rdata), 32'hABC);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      acks += int'(cpu_ack);
    end
    check("no_reack", 32'(acks), 0);
    cpu_req = 0;
    step();

    // Steal under continuous display
    disp_req  = 1;
    disp_addr = 10'd2;
    step();
    cpu_req  = 1;
    cpu_addr = 10'd5;
    n = 0;
    prev = disp_color;
    while (n < 20) begin
      prev      = disp_color;
      disp_addr = AW'($urandom);
      step();
      n++;
      if (cpu_ack)
        break;
    end
    check("steal_lat", 32'(n), 6);
    check("steal_flag", 32'(disp_stolen), 1);
    check("steal_color", 32'(disp_color), 32'(prev));
    check("steal_rdata", 32'(cpu_rdata), 32'hABC);
    cpu_req  = 0;
    disp_req = 0;
    step();
    step();

    // Collision from idle
    disp_req  = 1;
    disp_addr = 10'd7;
    cpu_req   = 1;
    cpu_addr  = 10'd9;
    step();
    check("col_disp", 32'(disp_color_valid), 1);
    check("col_pix", 32'(disp_color), 32'(mem[7]));
    check("col_noack", 32'(cpu_ack), 0);
    disp_req = 0;
    step();
    check("col_ack", 32'(cpu_ack), 1);
    check("col_rdata", 32'(cpu_rdata), 32'(mem[9]));
    cpu_req = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req) begin
        if ($urandom_range(3) == 0) begin
          cpu_req  = 1;
          cpu_addr = AW'($urandom);
        end
      end else if (m_need_low && $urandom_range(1) == 0) begin
        cpu_req = 0;
      end
      disp_req  = ($urandom_range(3) != 0);
      disp_addr = AW'($urandom);
      step();
    end

`ifdef BITMAP_ARB_STATS_EN
    check("steal_cnt", 32'(stat_steal_cnt), 32'(m_steals));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
